// File: rtl/multiword_prefix_adder.sv
// Streams A+B+cin through one 16-bit Kogge-Stone core, LSW first, carry chained in cr; 1-cycle latency.
// Single output register, in_ready = !out_valid || out_ready. Optional signed overflow port under MWADD_OVF_EN.

module prefix_adder16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  logic [15:0] p;
  logic [15:0] g0;
  logic [15:0] g1;
  logic [15:0] p1;
  logic [15:0] g2;
  logic [15:0] p2;
  logic [15:0] g3;
  logic [15:0] p3;
  logic [15:0] g4;

  // Carry-in is folded into bit 0 generate, so g4[i] is the carry out of bit i.
  always_comb begin
    p     = a ^ b;
    g0    = a & b;
    g0[0] = g0[0] | (p[0] & cin);
    g1    = g0 | (p  & (g0 << 1));
    p1    = p  & ((p  << 1) | 16'h0001);
    g2    = g1 | (p1 & (g1 << 2));
    p2    = p1 & ((p1 << 2) | 16'h0003);
    g3    = g2 | (p2 & (g2 << 4));
    p3    = p2 & ((p2 << 4) | 16'h000F);
    g4    = g3 | (p3 & (g3 << 8));
    sum   = p ^ {g4[14:0], cin};
    cout  = g4[15];
  end

endmodule

module multiword_prefix_adder #(
  parameter int WORDS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  input  logic        in_cin,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_sum,
  output logic        out_last,
  output logic        out_cout
`ifdef MWADD_OVF_EN
  ,
  output logic        out_ovf
`endif
);

  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

  typedef struct packed {
    logic [15:0] sum;
    logic        last;
    logic        cout;
  } out_reg_t;

  logic [IW-1:0] idx;
  logic          cr;
  out_reg_t      oreg;
  logic          accept;
  logic          is_first;
  logic          is_last;
  logic          core_cin;
  logic [15:0]   core_sum;
  logic          core_cout;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign is_first = (idx == '0);
  assign is_last  = (idx == LAST_IDX);
  assign core_cin = is_first ? in_cin : cr;

  prefix_adder16 u_core (
    .a    (in_a),
    .b    (in_b),
    .cin  (core_cin),
    .sum  (core_sum),
    .cout (core_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      oreg      <= '0;
      idx       <= '0;
      cr        <= 1'b0;
    end else if (accept) begin
      oreg.sum  <= core_sum;
      oreg.last <= is_last;
      oreg.cout <= is_last & core_cout;
      cr        <= core_cout;
      out_valid <= 1'b1;
      idx       <= is_last ? '0 : idx + IW'(1);
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign out_sum  = oreg.sum;
  assign out_last = oreg.last;
  assign out_cout = oreg.cout;

`ifdef MWADD_OVF_EN
  // Carry into bit 15 is recovered as a^b^sum at that bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_ovf <= 1'b0;
    end else if (accept) begin
      out_ovf <= is_last & ((in_a[15] ^ in_b[15] ^ core_sum[15]) ^ core_cout);
    end
  end
`endif

endmodule

// File: tb/tb_multiword_prefix_adder.sv
// Bench for multiword_prefix_adder (WORDS=4): vector table plus stall and mid-operation reset sequences.
module tb_multiword_prefix_adder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_a = '0;
  logic [15:0] in_b = '0;
  logic        in_cin = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_sum;
  logic        out_last;
  logic        out_cout;
`ifdef MWADD_OVF_EN
  logic        out_ovf;
`endif

  always #5 clk = ~clk;

  multiword_prefix_adder #(.WORDS(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_last  (out_last),
    .out_cout  (out_cout)
`ifdef MWADD_OVF_EN
    ,
    .out_ovf   (out_ovf)
`endif
  );

  typedef struct packed {
    logic [15:0] sum;
    logic        last;
    logic        cout;
    logic        ovf;
  } exp_t;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[7];
  int   n_checks = 0;
  int   n_fails  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Independent 65-bit reference: A+B+cin, overflow from operand/result signs.
  task automatic model(input logic [63:0] a, input logic [63:0] b, input logic cin,
                       output logic [63:0] s, output logic co, output logic ov);
    logic [64:0] full;
    full = {1'b0, a} + {1'b0, b} + {64'd0, cin};
    s    = full[63:0];
    co   = full[64];
    ov   = (a[63] == b[63]) && (full[63] != a[63]);
  endtask

  task automatic wait_accept();
    int n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 50) begin
        n_checks++;
        n_fails++;
        $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles", n);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_op(input logic [63:0] a, input logic [63:0] b, input logic cin,
                         input logic [63:0] s, input logic co, input logic ov);
    exp_t e;
    for (int w = 0; w < 4; w++) begin
      e.sum  = 16'(s >> (16 * w));
      e.last = (w == 3);
      e.cout = (w == 3) ? co : 1'b0;
      e.ovf  = (w == 3) ? ov : 1'b0;
      sb_q.push_back(e);
    end
    for (int w = 0; w < 4; w++) begin
      in_valid = 1'b1;
      in_a     = 16'(a >> (16 * w));
      in_b     = 16'(b >> (16 * w));
      in_cin   = (w == 0) ? cin : ~cin;
      wait_accept();
    end
    in_valid = 1'b0;
  endtask

  task automatic send_rand();
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] s;
    logic        cin;
    logic        co;
    logic        ov;
    a   = {$urandom(), $urandom()};
    b   = {$urandom(), $urandom()};
    cin = 1'($urandom_range(0, 1));
    model(a, b, cin, s, co, ov);
    send_op(a, b, cin, s, co, ov);
  endtask

  task automatic drain();
    int t = 0;
    while (sb_q.size() != 0 && t < 100) begin
      @(posedge clk);
      t++;
    end
    #1;
    check("scoreboard_drain", sb_q.size(), 0);
  endtask

  // Output words are compared in the cycle they are handed off.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          e = sb_q.pop_front();
          check("out_sum", out_sum, e.sum);
          check("out_last", out_last, e.last);
          check("out_cout", out_cout, e.cout);
`ifdef MWADD_OVF_EN
          check("out_ovf", out_ovf, e.ovf);
`endif
        end
      end
    end
  end

  initial begin
    exp_t e;
    vecs[0] = '{64'h0000_0000_0000_FFFF, 64'h0000_0000_0000_0001, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0};
    vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0, 64'h0000_0000_0000_0000, 1'b1, 1'b0};
    vecs[2] = '{64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000, 1'b1, 64'h0000_0000_0000_0001, 1'b0, 1'b0};
    vecs[3] = '{64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000, 1'b0, 64'h0000_0000_0000_0000, 1'b0, 1'b0};
    vecs[4] = '{64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 64'h2222_2222_2222_2212, 1'b0, 1'b0};
    vecs[5] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0000_0000_0000_0000, 1'b1, 1'b1};
    vecs[6] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};

    // Power-on reset state; out_ready low so in_ready reflects out_valid.
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sum", out_sum, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_cout", out_cout, 0);
`ifdef MWADD_OVF_EN
    check("rst_out_ovf", out_ovf, 0);
`endif
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1);
    out_ready = 1'b1;
    @(posedge clk);
    #1;

    // Table vectors issued back-to-back with no bubbles.
    for (int i = 0; i < 7; i++)
      send_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sum, vecs[i].cout, vecs[i].ovf);
    for (int i = 0; i < 3; i++)
      send_rand();
    drain();

    // Three-cycle stall after the second word is out.
    fork
      send_rand();
      begin
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          check("stall_in_ready", in_ready, 0);
          check("stall_out_valid", out_valid, 1);
          check("stall_out_sum", out_sum, sb_q[0].sum);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    send_rand();
    drain();

    // Reset after two accepted words of an operation.
    e = '{sum: 16'h0001, last: 1'b0, cout: 1'b0, ovf: 1'b0};
    sb_q.push_back(e);
    in_valid = 1'b1;
    in_a     = 16'hFFFF;
    in_b     = 16'h0001;
    in_cin   = 1'b1;
    @(posedge clk);
    #1;
    in_a     = 16'h0001;
    in_b     = 16'h0000;
    in_cin   = 1'b0;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_sum", out_sum, 0);
    check("midrst_out_last", out_last, 0);
    check("midrst_out_cout", out_cout, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midrst_in_ready", in_ready, 1);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    send_op(64'h0000_0000_0000_0005, 64'h0000_0000_0000_0003, 1'b0,
            64'h0000_0000_0000_0008, 1'b0, 1'b0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/multiword_prefix_adder.md
# multiword_prefix_adder

Sequential multi-word adder that streams two wide operands through a 16-bit parallel-prefix adder datapath one 16-bit word per cycle, least-significant word first, chaining the carry between words in a register. It sits directly around the team's 16-bit prefix adder core: it feeds the core's operand and carry-in inputs and consumes the core's sum and carry-out, adding valid/ready handshakes and word framing so wider additions (default 64-bit) reuse one 16-bit core.

## Interface
- `WORDS`, default 4: 16-bit words per operation; legal range 1..256.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: operand beat valid.
- `in_ready` output 1: block accepts a beat this cycle.
- `in_a` input 16: word of operand A.
- `in_b` input 16: word of operand B.
- `in_cin` input 1: carry-in for the operation; sampled only on word 0.
- `out_valid` output 1: sum word valid.
- `out_ready` input 1: downstream accepts the sum word.
- `out_sum` output 16: sum word.
- `out_last` output 1: `out_sum` is the final (most-significant) word.
- `out_cout` output 1: carry-out of the operation; meaningful only when `out_last`=1, else 0.
- `out_ovf` output 1 (only with `MWADD_OVF_EN`): signed overflow of the operation.

## Operation
- Beat accepted when `in_valid && in_ready`.
- `in_ready = !out_valid || out_ready`: single output register, combinational pass-through of downstream ready.
- Word counter `idx` (width `max(1,clog2(WORDS))`) counts accepted beats 0..WORDS-1, then wraps to 0; no framing input, the counter defines operation boundaries.
- Carry register `cr`. The adder core carry-in is `in_cin` when `idx`==0, else `cr`.
- On accept:
  - `out_sum` <= core sum.
  - `cr` <= core carry-out.
  - `out_last` <= (`idx`==WORDS-1).
  - `out_cout` <= core carry-out if last, else 0.
  - `out_valid` <= 1.
  - `idx` advances.
- If `out_valid && out_ready` and no accept: `out_valid` <= 0; `out_sum`, `out_last` and `out_cout` hold their values.
- Arithmetic is modulo 2^16 per word. The full result is `{out_cout, sum words}` = A + B + cin modulo 2^(16·WORDS+1).
- Effective states:
  - IDLE: `idx`=0, `out_valid`=0.
  - RUN: 0<`idx`<WORDS.
  - STALL: `out_valid`=1, `out_ready`=0. `in_ready`=0, all outputs frozen.
- `WORDS`=1: every beat is both first and last; `cr` is unused.

## Timing
- Reset (asynchronous assert, synchronous deassert expected):
  - `out_valid`=0, `out_sum`=0, `out_last`=0, `out_cout`=0, `out_ovf`=0.
  - `idx`=0, `cr`=0.
  - `in_ready`=1 on the first cycle after reset.
- Latency: 1 cycle from an accepted beat to `out_valid`.
- Throughput: 1 word/cycle while `out_ready`=1; full operation in WORDS cycles.
- Back-to-back operations need no bubble. Word 0 of the next operation may be accepted the cycle after the last word of the previous one.
- Reset mid-operation discards partial state. The next accepted beat is word 0 and uses `in_cin`.
- Stall holds `idx` and `cr`, so no beat is dropped or duplicated.
- Accepting a beat while the output is drained in the same cycle: the new word overwrites the register and `out_valid` stays 1.

## Configuration
- `MWADD_OVF_EN` defined:
  - Port `out_ovf` exists.
  - On the last word, `out_ovf` <= carry into bit 15 XOR carry out of bit 15, where carry into bit 15 = `a[15]^b[15]^sum[15]`.
  - On non-last words `out_ovf` <= 0.
  - `out_ovf` is frozen during a stall.
- `MWADD_OVF_EN` undefined: port and logic absent; all other behaviour is identical.

## Test plan
- Reset: assert `rst_n`=0 mid-stream -> immediately `out_valid`=0, `out_sum`=0, `out_last`=0, `out_cout`=0; after release `in_ready`=1.
- Carry ripple, WORDS=4, `out_ready`=1, cin=0:
  - A words FFFF,0000,0000,0000; B words 0001,0000,0000,0000.
  - Expect sums 0000,0001,0000,0000, with `out_last` only on the 4th word and `out_cout`=0.
- Full wrap: A=FFFF×4, B=0001,0000,0000,0000, cin=0 -> sums 0000×4, `out_cout`=1 on the last word.
- Carry-in: A=B=0, cin=1 -> sums 0001,0000,0000,0000. Then a second operation with cin=0, A=B=0 issued back-to-back -> sums 0000×4, showing `cr` is not reused.
- Backpressure: hold `out_ready`=0 for 3 cycles while `out_valid`=1 -> `in_ready`=0 and `out_sum` stable; after release the remaining words arrive in order with the correct carries.
- Reset after 2 accepted words, then A=0005,0,0,0, B=0003,0,0,0, cin=0 -> first output 0008, and `out_last` falls on the 4th word after reset.
- With `MWADD_OVF_EN`: A=FFFF,FFFF,FFFF,7FFF, B=0001,0000,0000,0000 -> `out_ovf`=1 and `out_cout`=0 on the last word.
